// File: rtl/processor_control_unit_if.sv
// Bus between the control unit and the datapath: instruction-memory fetch,
// data-memory controls, and register-file/ALU sequencing signals.
interface processor_control_unit_if #(
  parameter int PC_W = 7
);
  logic [15:0]     im_data;
  logic [PC_W-1:0] im_addr;
  logic [7:0]      d_addr;
  logic            d_rd;
  logic            d_wr;
  logic            rf_s;
  logic [3:0]      rf_w_addr;
  logic            rf_w_en;
  logic [3:0]      rf_ra_addr;
  logic            rf_ra_en;
  logic [3:0]      rf_rb_addr;
  logic            rf_rb_en;
  logic [2:0]      alu_s;
  logic [3:0]      state_out;

  // Control unit side: drives addresses, enables and selects.
  modport master (
    input  im_data,
    output im_addr, d_addr, d_rd, d_wr, rf_s,
    output rf_w_addr, rf_w_en, rf_ra_addr, rf_ra_en,
    output rf_rb_addr, rf_rb_en, alu_s, state_out
  );

  // Datapath / memory side: supplies instructions, consumes controls.
  modport slave (
    output im_data,
    input  im_addr, d_addr, d_rd, d_wr, rf_s,
    input  rf_w_addr, rf_w_en, rf_ra_addr, rf_ra_en,
    input  rf_rb_addr, rf_rb_en, alu_s, state_out
  );
endinterface

// File: rtl/processor_control_unit.sv
// Multi-cycle control unit: fetches 16-bit instructions into an IR, decodes
// them and sequences register-file, ALU and data-memory controls one
// instruction at a time. All outputs are decoded from registered state and IR.
module processor_control_unit #(
  parameter int PC_W    = 7,
  parameter int INIT_PC = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  processor_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(INIT_PC);

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic [3:0]      w_opcode;

  assign w_opcode = r_ir[15:12];

  // State register; reset forces INIT immediately, which zeroes all controls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // PC and IR load together only while leaving FETCH; PC wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= PC_RST;
      r_ir <= 16'h0000;
    end else if (r_state == S_FETCH) begin
      r_pc <= r_pc + 1'b1;
      r_ir <= bus.im_data;
    end
  end

  // Next-state logic; unknown opcodes fall into NOOP, HALT is terminal.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:   w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_STORE: w_next_state = S_STORE;
          OP_LOAD:  w_next_state = S_LOAD_A;
          OP_ADD:   w_next_state = S_ADD;
          OP_SUB:   w_next_state = S_SUB;
          OP_HALT:  w_next_state = S_HALT;
          default:  w_next_state = S_NOOP;
        endcase
      end
      S_NOOP:   w_next_state = S_FETCH;
      S_LOAD_A: w_next_state = S_LOAD_B;
      S_LOAD_B: w_next_state = S_FETCH;
      S_STORE:  w_next_state = S_FETCH;
      S_ADD:    w_next_state = S_FETCH;
      S_SUB:    w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_INIT;
    endcase
  end

  // Output decode from state and IR only; everything defaults to zero.
  always_comb begin
    bus.d_addr     = 8'h00;
    bus.d_rd       = 1'b0;
    bus.d_wr       = 1'b0;
    bus.rf_s       = 1'b0;
    bus.rf_w_addr  = 4'h0;
    bus.rf_w_en    = 1'b0;
    bus.rf_ra_addr = 4'h0;
    bus.rf_ra_en   = 1'b0;
    bus.rf_rb_addr = 4'h0;
    bus.rf_rb_en   = 1'b0;
    bus.alu_s      = 3'd0;
    case (r_state)
      S_LOAD_A: begin
        // Memory read issued here; data is valid in LOAD_B.
        bus.d_addr = r_ir[11:4];
        bus.d_rd   = 1'b1;
      end
      S_LOAD_B: begin
        bus.d_addr    = r_ir[11:4];
        bus.d_rd      = 1'b1;
        bus.rf_s      = 1'b1;
        bus.rf_w_addr = r_ir[3:0];
        bus.rf_w_en   = 1'b1;
      end
      S_STORE: begin
        // Register A passes through the ALU onto the memory write bus.
        bus.d_addr     = r_ir[7:0];
        bus.rf_ra_addr = r_ir[11:8];
        bus.rf_ra_en   = 1'b1;
        bus.alu_s      = 3'd0;
        bus.d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.rf_ra_addr = r_ir[11:8];
        bus.rf_ra_en   = 1'b1;
        bus.rf_rb_addr = r_ir[7:4];
        bus.rf_rb_en   = 1'b1;
        bus.alu_s      = (r_state == S_ADD) ? 3'd1 : 3'd2;
        bus.rf_s       = 1'b0;
        bus.rf_w_addr  = r_ir[3:0];
        bus.rf_w_en    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.im_addr   = r_pc;
  assign bus.state_out = r_state;

endmodule

// File: tb/tb_processor_control_unit.sv
// Directed bench for processor_control_unit: one task per scenario, each with
// hand-computed expected states and packed control-output vectors.
module tb_processor_control_unit;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  processor_control_unit_if #(.PC_W(7)) bus1 ();
  processor_control_unit_if #(.PC_W(3)) bus2 ();

  logic [15:0] mem1 [0:127];
  logic [15:0] mem2 [0:7];

  assign bus1.im_data = mem1[bus1.im_addr];
  assign bus2.im_data = mem2[bus2.im_addr];

  processor_control_unit #(.PC_W(7), .INIT_PC(0)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  processor_control_unit #(.PC_W(3), .INIT_PC(0)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packing: {d_addr, d_rd, d_wr, rf_s, w_addr, w_en, ra, ra_en, rb, rb_en, alu_s}
  localparam logic [28:0] O_IDLE  = 29'd0;
  localparam logic [28:0] O_LDA   = {8'h1A, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0};
  localparam logic [28:0] O_LDB   = {8'h1A, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0};
  localparam logic [28:0] O_ADD   = {8'h00, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 4'h0, 1'b1, 4'h1, 1'b1, 3'd1};
  localparam logic [28:0] O_SUB   = {8'h00, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 4'h2, 1'b1, 4'h1, 1'b1, 3'd2};
  localparam logic [28:0] O_ADD11 = {8'h00, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 4'h1, 1'b1, 3'd1};
  localparam logic [28:0] O_STORE = {8'h80, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h5, 1'b1, 4'h0, 1'b0, 3'd0};

  function automatic logic [28:0] outs1();
    return {bus1.d_addr, bus1.d_rd, bus1.d_wr, bus1.rf_s, bus1.rf_w_addr,
            bus1.rf_w_en, bus1.rf_ra_addr, bus1.rf_ra_en, bus1.rf_rb_addr,
            bus1.rf_rb_en, bus1.alu_s};
  endfunction

  task automatic load_prog(input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3);
    for (int i = 0; i < 128; i++) mem1[i] = 16'h5000;
    mem1[0] = p0; mem1[1] = p1; mem1[2] = p2; mem1[3] = p3;
  endtask

  // Hold reset for two cycles, release at a falling edge; caller sits at cycle 0.
  task automatic go();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] es [7];
    logic [6:0] ea [7];
    es = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd9, 4'd9, 4'd9};
    ea = '{7'd0, 7'd0, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1};
    load_prog(16'h5000, 16'h0000, 16'h0000, 16'h0000);
    reset = 1'b0;
    #3;
    tests++;
    if (bus1.state_out !== 4'd0 || bus1.im_addr !== 7'd0 || outs1() !== O_IDLE) begin
      fails++;
      $display("FAIL reset_state: state=%0d pc=%0d outs=%h, want state=0 pc=0 outs=0",
               bus1.state_out, bus1.im_addr, outs1());
    end
    go();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clock);
      tests++;
      if (bus1.state_out !== es[c] || bus1.im_addr !== ea[c] || outs1() !== O_IDLE) begin
        fails++;
        $display("FAIL halt_c%0d: state=%0d pc=%0d outs=%h, want state=%0d pc=%0d outs=0",
                 c, bus1.state_out, bus1.im_addr, outs1(), es[c], ea[c]);
      end
    end
  endtask

  task automatic test_load();
    logic [3:0]  es [8];
    logic [6:0]  ea [8];
    logic [28:0] eo [8];
    es = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd1, 4'd2, 4'd9};
    ea = '{7'd0, 7'd0, 7'd1, 7'd1, 7'd1, 7'd1, 7'd2, 7'd2};
    eo = '{O_IDLE, O_IDLE, O_IDLE, O_LDA, O_LDB, O_IDLE, O_IDLE, O_IDLE};
    load_prog(16'h21A3, 16'h5000, 16'h0000, 16'h0000);
    go();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clock);
      tests++;
      if (bus1.state_out !== es[c] || bus1.im_addr !== ea[c] || outs1() !== eo[c]) begin
        fails++;
        $display("FAIL load_c%0d: state=%0d pc=%0d outs=%h, want state=%0d pc=%0d outs=%h",
                 c, bus1.state_out, bus1.im_addr, outs1(), es[c], ea[c], eo[c]);
      end
    end
  endtask

  task automatic test_alu();
    load_prog(16'h3012, 16'h4214, 16'h3111, 16'h5000);
    go();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 3 || c == 6 || c == 9 || c == 12) begin
        logic [3:0]  st;
        logic [28:0] eo;
        st = (c == 3) ? 4'd7 : (c == 6) ? 4'd8 : (c == 9) ? 4'd7 : 4'd9;
        eo = (c == 3) ? O_ADD : (c == 6) ? O_SUB : (c == 9) ? O_ADD11 : O_IDLE;
        tests++;
        if (bus1.state_out !== st || outs1() !== eo) begin
          fails++;
          $display("FAIL alu_c%0d: state=%0d outs=%h, want state=%0d outs=%h",
                   c, bus1.state_out, outs1(), st, eo);
        end
      end
    end
  endtask

  task automatic test_store();
    load_prog(16'h1580, 16'h5000, 16'h0000, 16'h0000);
    go();
    repeat (3) @(negedge clock);
    tests++;
    if (bus1.state_out !== 4'd6 || outs1() !== O_STORE || bus1.rf_w_en === bus1.d_wr) begin
      fails++;
      $display("FAIL store: state=%0d outs=%h, want state=6 outs=%h",
               bus1.state_out, outs1(), O_STORE);
    end
    @(negedge clock);
    tests++;
    if (bus1.state_out !== 4'd1 || outs1() !== O_IDLE || bus1.im_addr !== 7'd1) begin
      fails++;
      $display("FAIL store_after: state=%0d pc=%0d outs=%h, want state=1 pc=1 outs=0",
               bus1.state_out, bus1.im_addr, outs1());
    end
  endtask

  task automatic test_pc_wrap();
    for (int i = 0; i < 8; i++) mem2[i] = 16'h0000;
    go();
    for (int c = 1; c <= 27; c++) begin
      @(negedge clock);
      if (c == 22) begin
        tests++;
        if (bus2.im_addr !== 3'd7 || bus2.state_out !== 4'd1) begin
          fails++;
          $display("FAIL wrap_pc7: pc=%0d state=%0d, want pc=7 state=1", bus2.im_addr, bus2.state_out);
        end
      end
      if (c == 23) begin
        tests++;
        if (bus2.im_addr !== 3'd0 || bus2.state_out !== 4'd2) begin
          fails++;
          $display("FAIL wrap_pc0: pc=%0d state=%0d, want pc=0 state=2", bus2.im_addr, bus2.state_out);
        end
      end
      if (c == 24) begin
        tests++;
        if (bus2.state_out !== 4'd3) begin
          fails++;
          $display("FAIL wrap_noop8: state=%0d, want 3", bus2.state_out);
        end
        mem2[0] = 16'hF000;
      end
      if (c == 27) begin
        tests++;
        if (bus2.state_out !== 4'd3 || bus2.im_addr !== 3'd1) begin
          fails++;
          $display("FAIL wrap_opF: state=%0d pc=%0d, want state=3 pc=1", bus2.state_out, bus2.im_addr);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    load_prog(16'h21A3, 16'h5000, 16'h0000, 16'h0000);
    go();
    repeat (4) @(negedge clock);
    tests++;
    if (bus1.rf_w_en !== 1'b1 || bus1.state_out !== 4'd5) begin
      fails++;
      $display("FAIL midrst_pre: w_en=%0d state=%0d, want w_en=1 state=5", bus1.rf_w_en, bus1.state_out);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (bus1.rf_w_en !== 1'b0 || bus1.state_out !== 4'd0 || bus1.im_addr !== 7'd0 || outs1() !== O_IDLE) begin
      fails++;
      $display("FAIL midrst_async: w_en=%0d state=%0d pc=%0d outs=%h, want 0 0 0 0",
               bus1.rf_w_en, bus1.state_out, bus1.im_addr, outs1());
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (bus1.state_out !== 4'd1 || bus1.im_addr !== 7'd0) begin
      fails++;
      $display("FAIL midrst_refetch: state=%0d pc=%0d, want state=1 pc=0", bus1.state_out, bus1.im_addr);
    end
    repeat (2) @(negedge clock);
    tests++;
    if (bus1.state_out !== 4'd4 || outs1() !== O_LDA || bus1.im_addr !== 7'd1) begin
      fails++;
      $display("FAIL midrst_restart: state=%0d pc=%0d outs=%h, want state=4 pc=1 outs=%h",
               bus1.state_out, bus1.im_addr, outs1(), O_LDA);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mem2[i] = 16'h0000;
    test_reset();
    test_load();
    test_alu();
    test_store();
    test_pc_wrap();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/processor_control_unit.md
Name: processor_control_unit

Overview:
- Multi-cycle control unit for the 16-register processor datapath; sits directly upstream of the register file.
- Fetches 16-bit instructions from instruction memory via a program counter and holds them in an instruction register.
- Decodes each instruction and sequences the register-file read/write addresses and enables, data-memory controls, ALU select and write-back mux select.
- Runs one instruction at a time through an FSM.

Parameters:
- PC_W, 7, program counter / instruction memory address width.
- INIT_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- im_data  input  16  instruction memory read data; asynchronous read of im_addr.
- im_addr  output  PC_W  current PC.
- d_addr  output  8  data memory address.
- d_rd  output  1  data memory read enable.
- d_wr  output  1  data memory write enable.
- rf_s  output  1  write-back select: 1 = data memory, 0 = ALU.
- rf_w_addr  output  4  register-file write address.
- rf_w_en  output  1  register-file write enable.
- rf_ra_addr  output  4  register-file A read address.
- rf_ra_en  output  1  register-file A read enable.
- rf_rb_addr  output  4  register-file B read address.
- rf_rb_en  output  1  register-file B read enable.
- alu_s  output  3  ALU function: 0 pass-A, 1 add, 2 sub.
- state_out  output  4  current state encoding, for debug display.

Behaviour:
- Instruction format:
  - [15:12] opcode.
  - LOAD: [11:4] d_addr, [3:0] rw.
  - STORE: [11:8] ra, [7:0] d_addr.
  - ADD/SUB: [11:8] ra, [7:4] rb, [3:0] rw.
- Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT. Opcodes 6-15 execute as NOOP.
- State encoding and transitions:
  - INIT=0 -> FETCH.
  - FETCH=1 -> DECODE.
  - DECODE=2 -> execute state selected by IR opcode.
  - NOOP=3 -> FETCH.
  - LOAD_A=4 -> LOAD_B.
  - LOAD_B=5 -> FETCH.
  - STORE=6 -> FETCH.
  - ADD=7 -> FETCH.
  - SUB=8 -> FETCH.
  - HALT=9 -> HALT; exited only by reset.
- FETCH: on the clock edge leaving FETCH, IR <= im_data and PC <= PC+1 together. PC wraps from 2^PC_W-1 to 0. PC and IR change only in FETCH.
- Outputs are decoded combinationally from the registered state and IR only, never from im_data. Every output not listed for a state is 0; addresses default to 0.
  - LOAD_A: d_addr=IR[11:4], d_rd=1. Memory data is valid the following cycle.
  - LOAD_B: d_addr=IR[11:4], d_rd=1, rf_s=1, rf_w_addr=IR[3:0], rf_w_en=1.
  - STORE: d_addr=IR[7:0], rf_ra_addr=IR[11:8], rf_ra_en=1, alu_s=0, d_wr=1.
  - ADD: rf_ra_addr=IR[11:8], rf_rb_addr=IR[7:4], both read enables=1, alu_s=1, rf_s=0, rf_w_addr=IR[3:0], rf_w_en=1.
  - SUB: same as ADD with alu_s=2.
- Invariants:
  - rf_ra_en and rf_rb_en are never 1 outside STORE/ADD/SUB; the register file drives its read buses only when enabled.
  - rf_w_en and d_wr are never 1 in the same cycle.
- Instruction latency: NOOP, STORE, ADD and SUB take 3 cycles; LOAD takes 4 cycles (FETCH, DECODE, LOAD_A, LOAD_B). The first FETCH is 1 cycle after reset release.
- Reset, asserted at any time including mid-LOAD or mid-STORE:
  - Immediately forces state=INIT, PC=INIT_PC, IR=0.
  - Drives all enables, d_wr and d_rd to 0 with no clock required, so no partial write occurs after assertion.
- Same-register operands, e.g. ADD R1,R1,R1, are legal. The register file reads the old value and writes the sum at the end of the ADD cycle.

Test Plan:
- Reset low then high; im_data = 0x5000 at PC 0 -> state_out sequence 0,1,2,9,9...; im_addr stays 1; all enables 0 throughout.
- Program LOAD R3,[0x1A] (0x21A3) -> LOAD_A: d_addr=0x1A, d_rd=1, rf_w_en=0; LOAD_B: rf_w_addr=3, rf_s=1, rf_w_en=1; next instruction fetched at cycle 5.
- ADD R2=R0+R1 (0x3012), then SUB R4=R2-R1 (0x4214) -> ADD cycle: ra=0, rb=1, w=2, alu_s=1, both read enables 1; SUB cycle: ra=2, rb=1, w=4, alu_s=2.
- STORE [0x80]<-R5 (0x1580) -> one cycle with d_wr=1, d_addr=0x80, rf_ra_addr=5, rf_ra_en=1, rf_rb_en=0, rf_w_en=0.
- PC wrap with PC_W=3: eight NOOPs (0x0000) then 0xF000 -> im_addr wraps 7->0; opcode F behaves as NOOP (state 3).
- Reset asserted during LOAD_B -> rf_w_en falls in the same cycle without a clock edge, state_out=0, im_addr=INIT_PC; after release, execution restarts from INIT_PC.
